// File: rtl/mm_agu_seq_if.sv
// Control/address bundle between the top-level control FSM, the matmul loop
// sequencer and the four-port address generator.
interface mm_agu_seq_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int DIM_W      = 11
);
   localparam int AW2 = ADDR_WIDTH + 2;

   logic             start;
   logic [DIM_W-1:0] n_rows;
   logic [DIM_W-1:0] n_cols;
   logic [DIM_W-1:0] k_len;
   logic [3:0]       stride_cfg;
   logic [AW2-1:0]   a_base;
   logic [AW2-1:0]   b_base;
   logic [AW2-1:0]   c_base;
   logic [AW2-1:0]   d_base;
   logic             stall;

   logic [3:0]       clr_en;
   logic [3:0]       add_en;
   logic [3:0]       stride;
   logic [AW2-1:0]   a_start;
   logic [AW2-1:0]   b_start;
   logic [AW2-1:0]   c_start;
   logic [AW2-1:0]   d_start;
   logic             mac_valid;
   logic             mac_first;
   logic             mac_last;
   logic             wr_en;
   logic             busy;
   logic             done;

   modport slave (
      input  start, n_rows, n_cols, k_len, stride_cfg,
             a_base, b_base, c_base, d_base, stall,
      output clr_en, add_en, stride, a_start, b_start, c_start, d_start,
             mac_valid, mac_first, mac_last, wr_en, busy, done
   );

   modport master (
      output start, n_rows, n_cols, k_len, stride_cfg,
             a_base, b_base, c_base, d_base, stall,
      input  clr_en, add_en, stride, a_start, b_start, c_start, d_start,
             mac_valid, mac_first, mac_last, wr_en, busy, done
   );
endinterface

// File: rtl/mm_agu_seq.sv
// Row-major loop-nest sequencer for D = A*B + C: drives clear/advance controls and
// next-dot-product start addresses so dot products run back-to-back.
module mm_agu_seq #(
   parameter int ADDR_WIDTH = 12,
   parameter int DIM_W      = 11,
   parameter int MAC_LAT    = 2
) (
   input  logic         clk,
   input  logic         rstn,
   mm_agu_seq_if.slave  bus
);
   localparam int AW2 = ADDR_WIDTH + 2;

   typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

   state_t           state, state_nx;
   logic [DIM_W-1:0] rows, cols, klen;
   logic [DIM_W-1:0] k, cur_r, cur_c, sc;
   logic [AW2-1:0]   a_step, b_step, b_base_q;
   logic [AW2-1:0]   a_st, b_st, c_st, d_st;
   logic [3:0]       stride_q;
   logic [MAC_LAT-1:0] last_pipe, pipe_shift;
   logic [3:0]       clr;
   logic [2:0]       add_lo;
   logic             latch, step, adv, k_last, dp_final, zero_dim;

   assign k_last     = (k == klen - DIM_W'(1));
   assign dp_final   = (cur_r == rows - DIM_W'(1)) && (cur_c == cols - DIM_W'(1));
   assign zero_dim   = (bus.n_rows == '0) || (bus.n_cols == '0) || (bus.k_len == '0);
   assign pipe_shift = last_pipe << 1;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx      = state;
      clr           = 4'b0000;
      add_lo        = 3'b000;
      bus.mac_valid = 1'b0;
      bus.mac_first = 1'b0;
      bus.mac_last  = 1'b0;
      latch         = 1'b0;
      step          = 1'b0;
      adv           = 1'b0;
      case (state)
         IDLE: if (bus.start) begin
            latch    = 1'b1;
            state_nx = zero_dim ? DONE : CLEAR;
         end
         CLEAR: begin
            clr      = 4'b1111;
            adv      = 1'b1;
            state_nx = RUN;
         end
         RUN: if (!bus.stall) begin
            step          = 1'b1;
            bus.mac_valid = 1'b1;
            bus.mac_first = (k == '0);
            bus.mac_last  = k_last;
            if (!k_last) begin
               add_lo = 3'b011;
            end else if (dp_final) begin
               add_lo   = 3'b111;
               state_nx = DRAIN;
            end else begin
               // clear wins over advance in the AGU, so A/B jump to the next bases
               add_lo = 3'b100;
               clr    = 4'b0011;
               adv    = 1'b1;
            end
         end
         // leave once the last pending write is leaving the pipe this cycle
         DRAIN: if (pipe_shift == '0) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rows <= '0; cols <= '0; klen <= '0;
         k <= '0; cur_r <= '0; cur_c <= '0; sc <= '0;
         a_step <= '0; b_step <= '0; b_base_q <= '0;
         a_st <= '0; b_st <= '0; c_st <= '0; d_st <= '0;
         stride_q  <= '0;
         last_pipe <= '0;
      end else begin
         last_pipe <= pipe_shift | MAC_LAT'(bus.mac_last);
         if (latch) begin
            rows     <= bus.n_rows;
            cols     <= bus.n_cols;
            klen     <= bus.k_len;
            stride_q <= bus.stride_cfg;
            a_step   <= AW2'(bus.k_len) << bus.stride_cfg[0];
            b_step   <= AW2'(bus.k_len) << bus.stride_cfg[1];
            b_base_q <= bus.b_base;
            a_st     <= bus.a_base;
            b_st     <= bus.b_base;
            c_st     <= bus.c_base;
            d_st     <= bus.d_base;
            k        <= '0;
            cur_r    <= '0;
            cur_c    <= '0;
            sc       <= '0;
         end
         if (step) begin
            k <= k_last ? '0 : k + DIM_W'(1);
            if (k_last && !dp_final) begin
               if (cur_c == cols - DIM_W'(1)) begin
                  cur_c <= '0;
                  cur_r <= cur_r + DIM_W'(1);
               end else begin
                  cur_c <= cur_c + DIM_W'(1);
               end
            end
         end
         // start registers always hold the bases of the dot product after the current one
         if (adv) begin
            if (sc == cols - DIM_W'(1)) begin
               sc   <= '0;
               a_st <= a_st + a_step;
               b_st <= b_base_q;
            end else begin
               sc   <= sc + DIM_W'(1);
               b_st <= b_st + b_step;
            end
         end
      end
   end

   assign bus.clr_en  = clr;
   assign bus.add_en  = {last_pipe[MAC_LAT-1], add_lo};
   assign bus.wr_en   = last_pipe[MAC_LAT-1];
   assign bus.stride  = stride_q;
   assign bus.a_start = a_st;
   assign bus.b_start = b_st;
   assign bus.c_start = c_st;
   assign bus.d_start = d_st;
   assign bus.busy    = (state != IDLE);
   assign bus.done    = (state == DONE);
endmodule

// File: tb/tb_mm_agu_seq.sv
// Table-driven bench for mm_agu_seq: a reference loop model fills step/write
// scoreboards at start; the monitor pops and compares as the DUT emits them.
module tb_mm_agu_seq;
   localparam int ADDR_WIDTH = 12;
   localparam int AW2        = ADDR_WIDTH + 2;
   localparam int DIM_W      = 11;
   localparam int MAC_LAT    = 2;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   mm_agu_seq_if #(.ADDR_WIDTH(ADDR_WIDTH), .DIM_W(DIM_W)) bus ();
   mm_agu_seq #(.ADDR_WIDTH(ADDR_WIDTH), .DIM_W(DIM_W), .MAC_LAT(MAC_LAT)) dut (
      .clk (clk),
      .rstn(rstn),
      .bus (bus)
   );

   typedef struct packed {
      logic [7:0]     t;
      logic           first;
      logic           last;
      logic [3:0]     clr;
      logic [2:0]     add;
      logic [AW2-1:0] a;
      logic [AW2-1:0] b;
   } step_t;

   typedef struct {
      string          name;
      int             r, n, k;
      logic [3:0]     s;
      logic [AW2-1:0] ab, bb, cb, db;
      int             st_lo, st_hi, busy_rel;
      int             exp_done, exp_steps, exp_wr;
   } vec_t;

   int    checks   = 0;
   int    failures = 0;
   int    cyc      = 0;
   string cur_name = "reset";
   step_t sq[$];
   int    wq[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s/%s: got %0h expected %0h", cur_name, nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input string nm, input int r, input int n, input int k,
                               input logic [3:0] s, input logic [AW2-1:0] ab,
                               input logic [AW2-1:0] bb, input logic [AW2-1:0] cb,
                               input logic [AW2-1:0] db, input int lo, input int hi,
                               input int br, input int dn, input int ns, input int nw);
      vec_t v;
      v.name = nm; v.r = r; v.n = n; v.k = k; v.s = s;
      v.ab = ab; v.bb = bb; v.cb = cb; v.db = db;
      v.st_lo = lo; v.st_hi = hi; v.busy_rel = br;
      v.exp_done = dn; v.exp_steps = ns; v.exp_wr = nw;
      return v;
   endfunction

   // Reference: walk the loop nest, skipping stalled cycles; bases by direct multiply.
   task automatic build(input vec_t v);
      int    t;
      int    nr, nc;
      bit    fin;
      step_t e;
      sq.delete();
      wq.delete();
      t = 2;
      if (v.r == 0 || v.n == 0 || v.k == 0) return;
      for (int r = 0; r < v.r; r++)
         for (int c = 0; c < v.n; c++)
            for (int k = 0; k < v.k; k++) begin
               while (t >= v.st_lo && t <= v.st_hi) t++;
               e       = '0;
               e.t     = 8'(t);
               e.first = (k == 0);
               e.last  = (k == v.k - 1);
               fin     = (r == v.r - 1) && (c == v.n - 1);
               if (!e.last) e.add = 3'b011;
               else if (fin) e.add = 3'b111;
               else begin
                  e.add = 3'b100;
                  e.clr = 4'b0011;
                  nr    = (c == v.n - 1) ? r + 1 : r;
                  nc    = (c == v.n - 1) ? 0 : c + 1;
                  e.a   = v.ab + AW2'(nr * (v.k << v.s[0]));
                  e.b   = v.bb + AW2'(nc * (v.k << v.s[1]));
               end
               if (e.last) wq.push_back(t + MAC_LAT);
               sq.push_back(e);
               t++;
            end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_ctl"}, 64'({bus.clr_en, bus.add_en, bus.stride, bus.mac_valid, bus.mac_first,
                             bus.mac_last, bus.wr_en, bus.busy, bus.done}), 64'(0));
      chk({nm, "_addr"}, 64'({bus.a_start, bus.b_start, bus.c_start, bus.d_start}), 64'(0));
   endtask

   task automatic drive(input vec_t v);
      bus.n_rows     = DIM_W'(v.r);
      bus.n_cols     = DIM_W'(v.n);
      bus.k_len      = DIM_W'(v.k);
      bus.stride_cfg = v.s;
      bus.a_base     = v.ab;
      bus.b_base     = v.bb;
      bus.c_base     = v.cb;
      bus.d_base     = v.db;
      bus.stall      = 1'b0;
      bus.start      = 1'b1;
   endtask

   task automatic run_case(input vec_t v);
      int    t0, rel, nsteps, nwr, wexp;
      bit    fin;
      step_t e, act;
      cur_name = v.name;
      @(posedge clk); #1;
      drive(v);
      t0 = cyc;
      build(v);
      nsteps = 0; nwr = 0; fin = 1'b0;
      for (int i = 0; i < 200 && !fin; i++) begin
         @(negedge clk);
         rel = cyc - t0;
         if (rel == 1 && v.exp_steps != 0) begin
            chk("clear_ctl", 64'({bus.clr_en, bus.add_en, bus.busy, bus.stride}),
                64'({4'b1111, 4'b0000, 1'b1, v.s}));
            chk("clear_bases", 64'({bus.a_start, bus.b_start, bus.c_start, bus.d_start}),
                64'({v.ab, v.bb, v.cb, v.db}));
         end else if (bus.mac_valid) begin
            if (sq.size() == 0) chk("extra_step", 64'(bus.mac_valid), 64'(0));
            else begin
               e         = sq.pop_front();
               act.t     = 8'(rel);
               act.first = bus.mac_first;
               act.last  = bus.mac_last;
               act.clr   = bus.clr_en;
               act.add   = bus.add_en[2:0];
               act.a     = e.clr[0] ? bus.a_start : '0;
               act.b     = e.clr[0] ? bus.b_start : '0;
               chk("step", 64'(act), 64'(e));
               nsteps++;
            end
         end else begin
            chk("quiet", 64'({bus.mac_first, bus.mac_last, bus.clr_en, bus.add_en[2:0]}), 64'(0));
         end
         if (bus.wr_en) begin
            nwr++;
            if (wq.size() == 0) chk("extra_wr", 64'(bus.wr_en), 64'(0));
            else begin
               wexp = wq.pop_front();
               chk("wr", 64'({bus.add_en[3], 32'(rel)}), 64'({1'b1, 32'(wexp)}));
            end
         end
         if (bus.done) begin
            chk("done", 64'({bus.busy, 32'(rel)}), 64'({1'b1, 32'(v.exp_done)}));
            fin = 1'b1;
         end else begin
            @(posedge clk); #1;
            rel       = cyc - t0;
            bus.start = (rel == v.busy_rel);
            if (rel == v.busy_rel) bus.n_cols = '0;
            bus.stall = (rel >= v.st_lo && rel <= v.st_hi);
         end
      end
      if (!fin) chk("timeout", 64'(bus.done), 64'(1));
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.stall = 1'b0;
      @(negedge clk);
      chk("after_done", 64'({bus.busy, bus.done}), 64'(0));
      chk("step_count", 64'(nsteps), 64'(v.exp_steps));
      chk("wr_count", 64'(nwr), 64'(v.exp_wr));
      chk("sb_empty", 64'(sq.size() + wq.size()), 64'(0));
   endtask

   initial begin
      vec_t vt[6];
      int   t0;
      vt[0] = mk("base",   2, 2, 3, 4'b0000, 14'h000, 14'h100, 14'h200, 14'h300, 1, 0, -1, 16, 12, 4);
      vt[1] = mk("stall",  2, 2, 3, 4'b0000, 14'h000, 14'h100, 14'h200, 14'h300, 5, 7, -1, 19, 12, 4);
      vt[2] = mk("k1",     1, 3, 1, 4'b0010, 14'h000, 14'h100, 14'h200, 14'h300, 1, 0, -1,  7,  3, 3);
      vt[3] = mk("zero",   2, 0, 3, 4'b0000, 14'h000, 14'h100, 14'h200, 14'h300, 1, 0, -1,  1,  0, 0);
      vt[4] = mk("busy_start", 2, 2, 3, 4'b0000, 14'h000, 14'h100, 14'h200, 14'h300, 1, 0, 5, 16, 12, 4);
      vt[5] = mk("wrap",   3, 2, 2, 4'b0011, 14'h3FFC, 14'h3FF0, 14'h010, 14'h020, 1, 0, -1, 16, 12, 6);

      rstn = 1'b0;
      bus.start = 1'b0; bus.stall = 1'b0; bus.stride_cfg = '0;
      bus.n_rows = '0; bus.n_cols = '0; bus.k_len = '0;
      bus.a_base = '0; bus.b_base = '0; bus.c_base = '0; bus.d_base = '0;
      #12;
      chk_all_zero("reset");
      @(posedge clk); #1;
      rstn = 1'b1;

      for (int i = 0; i < 6; i++) run_case(vt[i]);

      // reset in the middle of RUN, then the same job again
      cur_name = "mid_reset";
      @(posedge clk); #1;
      drive(vt[0]);
      t0 = cyc;
      while (cyc - t0 < 6) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
      end
      rstn = 1'b0;
      #1;
      chk_all_zero("async");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("no_done", 64'({bus.done, bus.busy}), 64'(0));
      end
      @(posedge clk); #1;
      rstn = 1'b1;
      run_case(vt[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
